// File: rtl/pcpi_bridge_pkg.sv
// ----------------------------------------------------------------------------
// pcpi_bridge_pkg
// Shared definitions for the serial-to-PCPI bridge:
//   - FSM state encoding (enum and matching localparam constants)
//   - default segment / instruction / result widths
//   - index-width helper used to size the segment counters
// ----------------------------------------------------------------------------
package pcpi_bridge_pkg;

    localparam logic [1:0] ST_LOAD   = 2'b00;
    localparam logic [1:0] ST_ISSUE  = 2'b01;
    localparam logic [1:0] ST_UNLOAD = 2'b10;

    typedef enum logic [1:0] {
        LOAD   = ST_LOAD,
        ISSUE  = ST_ISSUE,
        UNLOAD = ST_UNLOAD
    } bridge_state_e;

    localparam int DEF_SEG_W  = 4;
    localparam int DEF_INSN_W = 32;
    localparam int DEF_RES_W  = 32;

    // Counter width able to index max(a, b) segments; never narrower than 1 bit.
    function automatic int idx_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/pcpi_serial_bridge_if.sv
// ----------------------------------------------------------------------------
// pcpi_serial_bridge_if
// PCPI handshake bundle between the serial bridge and a coprocessor.
//   pcpi_valid / pcpi_insn : bridge -> coprocessor
//   pcpi_ready / pcpi_wr / pcpi_wait / pcpi_rd : coprocessor -> bridge
// Modports: master = bridge side, slave = coprocessor side.
// ----------------------------------------------------------------------------
interface pcpi_serial_bridge_if
    import pcpi_bridge_pkg::*;
#(
    parameter int INSN_W = DEF_INSN_W,
    parameter int RES_W  = DEF_RES_W
) ();

    logic              pcpi_valid;
    logic [INSN_W-1:0] pcpi_insn;
    logic              pcpi_ready;
    logic              pcpi_wr;
    logic              pcpi_wait;
    logic [RES_W-1:0]  pcpi_rd;

    modport master (
        output pcpi_valid, pcpi_insn,
        input  pcpi_ready, pcpi_wr, pcpi_wait, pcpi_rd
    );

    modport slave (
        input  pcpi_valid, pcpi_insn,
        output pcpi_ready, pcpi_wr, pcpi_wait, pcpi_rd
    );

endinterface

// File: rtl/pcpi_seg_serializer.sv
// ----------------------------------------------------------------------------
// pcpi_seg_serializer
// Holds a parallel-loaded result word and presents it one SEG_W segment at a
// time, LSB segment first.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture load_data, restart at segment 0
//   load_data  : RES_W-bit result word
//   advance    : current segment consumed, move to the next (wraps after last)
//   seg_out    : segment selected by idx
//   idx        : current segment index
// ----------------------------------------------------------------------------
module pcpi_seg_serializer
    import pcpi_bridge_pkg::*;
#(
    parameter int SEG_W = DEF_SEG_W,
    parameter int RES_W = DEF_RES_W,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [RES_W-1:0] load_data,
    input  logic             advance,
    output logic [SEG_W-1:0] seg_out,
    output logic [IDX_W-1:0] idx
);

    localparam int              NRES     = RES_W / SEG_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NRES - 1);

    logic [RES_W-1:0] res_r;
    logic [IDX_W-1:0] idx_r;
    logic [SEG_W-1:0] seg_s;

    // Result register and segment index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_r <= '0;
            idx_r <= '0;
        end else if (load) begin
            res_r <= load_data;
            idx_r <= '0;
        end else if (advance) begin
            if (idx_r == LAST_IDX) begin
                idx_r <= '0;
            end else begin
                idx_r <= idx_r + IDX_W'(1);
            end
        end
    end

    // Segment select: shift the held word down by idx segments.
    always_comb begin
        seg_s = SEG_W'(res_r >> (32'(idx_r) * SEG_W));
    end

    assign seg_out = seg_s;
    assign idx     = idx_r;

endmodule

// File: rtl/pcpi_serial_bridge.sv
// ----------------------------------------------------------------------------
// pcpi_serial_bridge
// Loads a coprocessor instruction SEG_W bits per cycle, issues it over PCPI
// with a valid/ready handshake, and returns a written-back result serially.
// Optional feature macro: PCPI_BRIDGE_TIMEOUT_EN (abort ISSUE after
// TIMEOUT_CYC non-waiting cycles without pcpi_ready, sticky err_timeout).
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   seg_in/seg_valid  : instruction segment input, LSB segment first
//   seg_ready         : high in LOAD
//   pcpi (master)     : PCPI handshake bundle
//   res_seg/res_valid : result segment output, LSB segment first
//   res_ready         : host consumes res_seg
//   busy              : any state other than LOAD
//   err_timeout       : sticky abort flag, cleared by next accepted segment
// ----------------------------------------------------------------------------
module pcpi_serial_bridge
    import pcpi_bridge_pkg::*;
#(
    parameter int SEG_W       = DEF_SEG_W,
    parameter int INSN_W      = DEF_INSN_W,
    parameter int RES_W       = DEF_RES_W,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [SEG_W-1:0]     seg_in,
    input  logic                 seg_valid,
    output logic                 seg_ready,
    pcpi_serial_bridge_if.master pcpi,
    output logic [SEG_W-1:0]     res_seg,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic                 busy,
    output logic                 err_timeout
);

    localparam int NSEG  = INSN_W / SEG_W;
    localparam int NRES  = RES_W / SEG_W;
    localparam int IDX_W = idx_width(NSEG, NRES);

    localparam logic [IDX_W-1:0] LAST_SEG = IDX_W'(NSEG - 1);
    localparam logic [IDX_W-1:0] LAST_RES = IDX_W'(NRES - 1);

    if ((INSN_W % SEG_W) != 0) begin : g_bad_insn_w
        $error("INSN_W must be a multiple of SEG_W");
    end
    if ((RES_W % SEG_W) != 0) begin : g_bad_res_w
        $error("RES_W must be a multiple of SEG_W");
    end
    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 2");
    end

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic [IDX_W-1:0]  idx_r;
    logic [INSN_W-1:0] insn_r;
    logic [IDX_W-1:0]  ser_idx_s;
    logic              timeout_hit_s;
    logic              accept_s;
    logic              res_load_s;
    logic              res_adv_s;

    assign accept_s   = (state_r == ST_LOAD) && seg_valid;
    assign res_load_s = (state_r == ST_ISSUE) && pcpi.pcpi_ready && pcpi.pcpi_wr;
    assign res_adv_s  = (state_r == ST_UNLOAD) && res_ready;

    // Next-state decode; pcpi_ready takes priority over a simultaneous timeout.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_LOAD: begin
                if (seg_valid && (idx_r == LAST_SEG)) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_ISSUE: begin
                if (pcpi.pcpi_ready) begin
                    state_nxt_s = pcpi.pcpi_wr ? ST_UNLOAD : ST_LOAD;
                end else if (timeout_hit_s) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_UNLOAD: begin
                if (res_ready && (ser_idx_s == LAST_RES)) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_UNLOAD;
                end
            end
            default: begin
                state_nxt_s = ST_LOAD;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_LOAD;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Instruction assembly: write the accepted segment into its slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            insn_r <= '0;
            idx_r  <= '0;
        end else if (accept_s) begin
            for (int i = 0; i < NSEG; i++) begin
                if (idx_r == IDX_W'(i)) begin
                    insn_r[i*SEG_W +: SEG_W] <= seg_in;
                end
            end
            if (idx_r == LAST_SEG) begin
                idx_r <= '0;
            end else begin
                idx_r <= idx_r + IDX_W'(1);
            end
        end
    end

`ifdef PCPI_BRIDGE_TIMEOUT_EN
    localparam int               TCNT_W    = $clog2(TIMEOUT_CYC);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYC - 1);

    logic [TCNT_W-1:0] tcnt_r;
    logic              err_r;

    assign timeout_hit_s = (state_r == ST_ISSUE) && !pcpi.pcpi_wait && (tcnt_r == TCNT_LAST);

    // Non-waiting ISSUE cycle counter; held at 0 outside ISSUE so entry starts at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt_r <= '0;
        end else if ((state_r != ST_ISSUE) || pcpi.pcpi_wait) begin
            tcnt_r <= '0;
        end else if (tcnt_r != TCNT_LAST) begin
            tcnt_r <= tcnt_r + TCNT_W'(1);
        end
    end

    // Sticky abort flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else if (timeout_hit_s && !pcpi.pcpi_ready) begin
            err_r <= 1'b1;
        end else if (accept_s) begin
            err_r <= 1'b0;
        end
    end

    assign err_timeout = err_r;
`else
    logic unused_wait_s;

    assign unused_wait_s = pcpi.pcpi_wait;
    assign timeout_hit_s = 1'b0;
    assign err_timeout   = 1'b0;
`endif

    pcpi_seg_serializer #(
        .SEG_W (SEG_W),
        .RES_W (RES_W),
        .IDX_W (IDX_W)
    ) u_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (res_load_s),
        .load_data (pcpi.pcpi_rd),
        .advance   (res_adv_s),
        .seg_out   (res_seg),
        .idx       (ser_idx_s)
    );

    assign seg_ready       = (state_r == ST_LOAD);
    assign busy            = (state_r != ST_LOAD);
    assign res_valid       = (state_r == ST_UNLOAD);
    assign pcpi.pcpi_valid = (state_r == ST_ISSUE);
    assign pcpi.pcpi_insn  = insn_r;

endmodule

// File: tb/tb_pcpi_serial_bridge.sv
// ----------------------------------------------------------------------------
// tb_pcpi_serial_bridge
// Two bridge instances: dut_a (SEG_W=4, TIMEOUT_CYC=8) and dut_b (SEG_W=8).
// Expected result segments are queued when a write-back is driven and popped
// by a monitor whenever the bridge presents a result segment.
// ----------------------------------------------------------------------------
module tb_pcpi_serial_bridge;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    // ---------------- dut_a: SEG_W = 4 ----------------
    logic [3:0] a_seg_in;
    logic       a_seg_valid, a_seg_ready;
    logic [3:0] a_res_seg;
    logic       a_res_valid, a_res_ready, a_busy, a_err;

    pcpi_serial_bridge_if #(.INSN_W(32), .RES_W(32)) a_if ();

    pcpi_serial_bridge #(.SEG_W(4), .INSN_W(32), .RES_W(32), .TIMEOUT_CYC(8)) dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (a_seg_in),
        .seg_valid   (a_seg_valid),
        .seg_ready   (a_seg_ready),
        .pcpi        (a_if.master),
        .res_seg     (a_res_seg),
        .res_valid   (a_res_valid),
        .res_ready   (a_res_ready),
        .busy        (a_busy),
        .err_timeout (a_err)
    );

    // ---------------- dut_b: SEG_W = 8 ----------------
    logic [7:0] b_seg_in;
    logic       b_seg_valid, b_seg_ready;
    logic [7:0] b_res_seg;
    logic       b_res_valid, b_res_ready, b_busy, b_err;

    pcpi_serial_bridge_if #(.INSN_W(32), .RES_W(32)) b_if ();

    pcpi_serial_bridge #(.SEG_W(8), .INSN_W(32), .RES_W(32)) dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (b_seg_in),
        .seg_valid   (b_seg_valid),
        .seg_ready   (b_seg_ready),
        .pcpi        (b_if.master),
        .res_seg     (b_res_seg),
        .res_valid   (b_res_valid),
        .res_ready   (b_res_ready),
        .busy        (b_busy),
        .err_timeout (b_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0] a_q[$];
    logic [7:0] b_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_a(input logic [31:0] insn);
        for (int i = 0; i < 8; i++) begin
            check("a_seg_ready_load", 64'(a_seg_ready), 64'd1);
            a_seg_in    = insn[i*4 +: 4];
            a_seg_valid = 1'b1;
            tick();
        end
        a_seg_valid = 1'b0;
        check("a_valid_after_load", 64'(a_if.pcpi_valid), 64'd1);
        check("a_insn", 64'(a_if.pcpi_insn), 64'(insn));
    endtask

    task automatic wait_a_unload(input int exp_cycles);
        int n;
        n = 0;
        while (!a_seg_ready && n < 40) begin
            tick();
            n++;
        end
        check("a_unload_done", 64'(a_seg_ready), 64'd1);
        check("a_unload_cycles", 64'(n), 64'(exp_cycles));
        check("a_queue_empty", 64'(a_q.size()), 64'd0);
    endtask

    // Result monitor for dut_a: samples mid-cycle, pops on consumption.
    always @(negedge clk) begin
        if (rst_n && a_res_valid) begin
            if (a_q.size() == 0) begin
                check("a_res_unexpected", 64'(a_q.size()), 64'd1);
            end else if (a_res_ready) begin
                check("a_res_seg", 64'(a_res_seg), 64'(a_q.pop_front()));
            end else begin
                check("a_res_hold", 64'(a_res_seg), 64'(a_q[0]));
            end
        end
    end

    // Result monitor for dut_b.
    always @(negedge clk) begin
        if (rst_n && b_res_valid) begin
            if (b_q.size() == 0) begin
                check("b_res_unexpected", 64'(b_q.size()), 64'd1);
            end else if (b_res_ready) begin
                check("b_res_seg", 64'(b_res_seg), 64'(b_q.pop_front()));
            end else begin
                check("b_res_hold", 64'(b_res_seg), 64'(b_q[0]));
            end
        end
    end

    // Global run-time bound.
    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "time limit");
    end

    initial begin
        logic [31:0] insn;
        logic [31:0] rd;
        int          n;

        rst_n          = 1'b0;
        a_seg_in       = 4'h0;
        a_seg_valid    = 1'b0;
        a_res_ready    = 1'b0;
        a_if.pcpi_ready = 1'b0;
        a_if.pcpi_wr   = 1'b0;
        a_if.pcpi_wait = 1'b0;
        a_if.pcpi_rd   = 32'h0;
        b_seg_in       = 8'h0;
        b_seg_valid    = 1'b0;
        b_res_ready    = 1'b0;
        b_if.pcpi_ready = 1'b0;
        b_if.pcpi_wr   = 1'b0;
        b_if.pcpi_wait = 1'b0;
        b_if.pcpi_rd   = 32'h0;

        #12;
        check("rst_seg_ready", 64'(a_seg_ready), 64'd1);
        check("rst_busy", 64'(a_busy), 64'd0);
        check("rst_pcpi_valid", 64'(a_if.pcpi_valid), 64'd0);
        check("rst_res_valid", 64'(a_res_valid), 64'd0);
        check("rst_err", 64'(a_err), 64'd0);
        check("rst_res_seg", 64'(a_res_seg), 64'd0);
        check("rst_insn", 64'(a_if.pcpi_insn), 64'd0);

        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Directed load, 5 stall cycles, write-back of 0x12345678.
        load_a(32'hB000_0003);
        check("a_busy_issue", 64'(a_busy), 64'd1);
        check("a_seg_ready_issue", 64'(a_seg_ready), 64'd0);
        a_if.pcpi_wait = 1'b1;
        a_seg_in       = 4'hF;
        a_seg_valid    = 1'b1;
        a_res_ready    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("a_valid_stall", 64'(a_if.pcpi_valid), 64'd1);
            tick();
        end
        a_seg_valid = 1'b0;
        check("a_insn_stable", 64'(a_if.pcpi_insn), 64'hB000_0003);
        check("a_valid_before_ready", 64'(a_if.pcpi_valid), 64'd1);
        a_if.pcpi_ready = 1'b1;
        a_if.pcpi_wr    = 1'b1;
        a_if.pcpi_rd    = 32'h1234_5678;
        for (int i = 0; i < 8; i++) a_q.push_back(a_if.pcpi_rd[i*4 +: 4]);
        tick();
        a_if.pcpi_ready = 1'b0;
        a_if.pcpi_wr    = 1'b0;
        a_if.pcpi_wait  = 1'b0;
        check("a_valid_drop", 64'(a_if.pcpi_valid), 64'd0);
        check("a_res_valid_rise", 64'(a_res_valid), 64'd1);
        wait_a_unload(8);
        a_res_ready = 1'b0;

        // pcpi_ready while in LOAD is ignored.
        a_if.pcpi_ready = 1'b1;
        a_if.pcpi_wr    = 1'b1;
        a_if.pcpi_rd    = 32'hFFFF_FFFF;
        tick();
        a_if.pcpi_ready = 1'b0;
        a_if.pcpi_wr    = 1'b0;
        check("a_ready_in_load_res", 64'(a_res_valid), 64'd0);
        check("a_ready_in_load_busy", 64'(a_busy), 64'd0);

        // Random round trips with write-back.
        for (int k = 0; k < 3; k++) begin
            insn = $urandom();
            rd   = $urandom();
            load_a(insn);
            a_res_ready     = 1'b1;
            a_if.pcpi_ready = 1'b1;
            a_if.pcpi_wr    = 1'b1;
            a_if.pcpi_rd    = rd;
            for (int i = 0; i < 8; i++) a_q.push_back(rd[i*4 +: 4]);
            tick();
            a_if.pcpi_ready = 1'b0;
            a_if.pcpi_wr    = 1'b0;
            wait_a_unload(8);
            a_res_ready = 1'b0;
        end

        // No write-back: straight back to LOAD.
        load_a(32'h0F1E_2D3C);
        a_if.pcpi_ready = 1'b1;
        a_if.pcpi_wr    = 1'b0;
        tick();
        a_if.pcpi_ready = 1'b0;
        check("a_nowb_res_valid", 64'(a_res_valid), 64'd0);
        check("a_nowb_seg_ready", 64'(a_seg_ready), 64'd1);
        check("a_nowb_valid", 64'(a_if.pcpi_valid), 64'd0);

`ifdef PCPI_BRIDGE_TIMEOUT_EN
        // Abort after 8 non-waiting ISSUE cycles.
        load_a(32'h1111_2222);
        n = 0;
        while (a_if.pcpi_valid && n < 30) begin
            tick();
            n++;
        end
        check("a_timeout_cycles", 64'(n), 64'd8);
        check("a_timeout_err", 64'(a_err), 64'd1);
        check("a_timeout_seg_ready", 64'(a_seg_ready), 64'd1);
        // Next load clears the flag; pcpi_wait holds off the timeout.
        a_if.pcpi_wait = 1'b1;
        load_a(32'h3333_4444);
        check("a_err_cleared", 64'(a_err), 64'd0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (a_if.pcpi_valid) n++;
            tick();
        end
        check("a_wait_no_abort", 64'(n), 64'd20);
        a_if.pcpi_wait = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check("a_valid_at_expiry", 64'(a_if.pcpi_valid), 64'd1);
        // Ready on the expiry cycle wins over the abort.
        a_if.pcpi_ready = 1'b1;
        a_if.pcpi_wr    = 1'b0;
        tick();
        a_if.pcpi_ready = 1'b0;
        check("a_ready_wins_err", 64'(a_err), 64'd0);
        check("a_ready_wins_load", 64'(a_seg_ready), 64'd1);
`else
        // Without the timeout ISSUE waits indefinitely.
        load_a(32'h1111_2222);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (a_if.pcpi_valid) n++;
            tick();
        end
        check("a_no_timeout_valid", 64'(n), 64'd100);
        check("a_no_timeout_err", 64'(a_err), 64'd0);
        a_if.pcpi_ready = 1'b1;
        a_if.pcpi_wr    = 1'b0;
        tick();
        a_if.pcpi_ready = 1'b0;
        check("a_no_timeout_done", 64'(a_seg_ready), 64'd1);
`endif

        // Asynchronous reset in the middle of ISSUE.
        load_a(32'hA5A5_5A5A);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 64'(a_if.pcpi_valid), 64'd0);
        check("rst_mid_seg_ready", 64'(a_seg_ready), 64'd1);
        check("rst_mid_busy", 64'(a_busy), 64'd0);
        check("rst_mid_insn", 64'(a_if.pcpi_insn), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // dut_b: 8-bit segments, res_ready toggling.
        insn = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            check("b_seg_ready_load", 64'(b_seg_ready), 64'd1);
            b_seg_in    = insn[i*8 +: 8];
            b_seg_valid = 1'b1;
            tick();
        end
        b_seg_valid = 1'b0;
        check("b_valid_after_load", 64'(b_if.pcpi_valid), 64'd1);
        check("b_insn", 64'(b_if.pcpi_insn), 64'hDEAD_BEEF);
        b_if.pcpi_wait = 1'b1;
        tick();
        tick();
        b_if.pcpi_ready = 1'b1;
        b_if.pcpi_wr    = 1'b1;
        b_if.pcpi_rd    = 32'hCAFE_F00D;
        for (int i = 0; i < 4; i++) b_q.push_back(b_if.pcpi_rd[i*8 +: 8]);
        tick();
        b_if.pcpi_ready = 1'b0;
        b_if.pcpi_wr    = 1'b0;
        b_if.pcpi_wait  = 1'b0;
        check("b_res_valid_rise", 64'(b_res_valid), 64'd1);
        n = 0;
        while (!b_seg_ready && n < 40) begin
            b_res_ready = (n % 2 == 1);
            tick();
            n++;
        end
        b_res_ready = 1'b0;
        check("b_unload_done", 64'(b_seg_ready), 64'd1);
        check("b_unload_cycles", 64'(n), 64'd8);
        check("b_queue_empty", 64'(b_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pcpi_serial_bridge.md
# pcpi_serial_bridge

Parametrised serial-to-PCPI bridge for the TinyTapeout pin budget. It loads a coprocessor instruction a few bits per cycle from dedicated inputs and issues it to a PCPI coprocessor with a full valid/ready handshake. It waits out `pcpi_wait` stalls, with an optional timeout. When the coprocessor writes back, it returns the result serially over the same segment width. It sits between the `tt_um_*` top-level pins and the coprocessor instance.

## Interface
- `SEG_W`, 4: bits per transferred segment, for both load and unload.
- `INSN_W`, 32: instruction width. Must be a multiple of `SEG_W`, otherwise elaboration fails.
- `RES_W`, 32: result width. Must be a multiple of `SEG_W`.
- `TIMEOUT_CYC`, 64: number of non-waiting cycles without `pcpi_ready` before an abort. Minimum value is 2.

Ports:
- `clk`  in  1: single clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `seg_in`  in  SEG_W: instruction segment, LSB segment first.
- `seg_valid`  in  1: `seg_in` is valid this cycle.
- `seg_ready`  out  1: bridge accepts a segment this cycle.
- `pcpi_valid`  out  1: instruction presented to the coprocessor.
- `pcpi_insn`  out  INSN_W: assembled instruction.
- `pcpi_ready`  in  1: coprocessor done, single-cycle pulse.
- `pcpi_wr`  in  1: result is to be written back; qualified by `pcpi_ready`.
- `pcpi_wait`  in  1: coprocessor is busy; suspends the timeout.
- `pcpi_rd`  in  RES_W: result; qualified by `pcpi_ready`.
- `res_seg`  out  SEG_W: result segment, LSB segment first.
- `res_valid`  out  1: `res_seg` is valid.
- `res_ready`  in  1: host consumes `res_seg`.
- `busy`  out  1: high in any state other than LOAD.
- `err_timeout`  out  1: sticky. Set on abort; cleared by the next accepted segment.

## Operation
- Derived constants: NSEG = INSN_W/SEG_W; NRES = RES_W/SEG_W.
- Counter width is $clog2(max(NSEG, NRES)).
- LOAD:
  - `seg_ready` = 1.
  - When `seg_valid` is high, write `seg_in` into `pcpi_insn[idx*SEG_W +: SEG_W]` and increment `idx`.
  - When the segment with idx = NSEG-1 is accepted, clear `idx` and go to ISSUE.
- ISSUE:
  - `pcpi_valid` = 1, held until `pcpi_ready` is sampled high.
  - `pcpi_insn` is stable throughout.
  - `pcpi_ready` with `pcpi_wr` = 1: latch `pcpi_rd` into the result register and go to UNLOAD.
  - `pcpi_ready` with `pcpi_wr` = 0: go to LOAD.
- Timeout (only with the macro enabled):
  - `tcnt` increments on each ISSUE cycle in which `pcpi_wait` is 0.
  - `tcnt` clears on entering ISSUE and on any cycle in which `pcpi_wait` is 1.
  - When `tcnt` reaches TIMEOUT_CYC-1 without `pcpi_ready`, set `err_timeout`, drop `pcpi_valid` and go to LOAD.
- UNLOAD:
  - `res_valid` = 1, `res_seg` = segment `idx` of the result register.
  - Each cycle with `res_ready` high advances `idx`.
  - After segment NRES-1 is consumed, clear `idx` and go to LOAD.
- Boundary cases:
  - `seg_valid` outside LOAD is ignored; `seg_ready` is low there.
  - `pcpi_ready` outside ISSUE is ignored.
  - `pcpi_ready` on the same cycle as timeout expiry: ready wins; no error is flagged.
  - `res_ready` while `res_valid` is low is ignored.
  - Segments are contiguous by index; there is no back-pressure on the coprocessor side.
- Reset, asynchronous and valid mid-operation:
  - State returns to LOAD; `idx` and `tcnt` are cleared.
  - `pcpi_valid`, `res_valid` and `err_timeout` go to 0.
  - `pcpi_insn` and the result register go to 0, so `res_seg` reads 0.
  - `seg_ready` reads 1 after reset; `busy` reads 0.

## Timing
- All outputs are registered or decoded from state; there are no combinational paths from inputs to outputs.
- Last segment accepted at cycle N: `pcpi_valid` goes high at N+1.
- `pcpi_ready` sampled at cycle M:
  - `pcpi_valid` is low at M+1.
  - With write-back, `res_valid` goes high at M+1.
  - Without write-back, `seg_ready` goes high at M+1.
- Best case end-to-end: NSEG load cycles, then 1 issue cycle plus coprocessor latency, then NRES unload cycles.
- Timeout abort: with `pcpi_wait` held at 0 from ISSUE entry at cycle E, the abort happens at E+TIMEOUT_CYC-1 and `err_timeout` is high at E+TIMEOUT_CYC.

## Configuration
- `PCPI_BRIDGE_TIMEOUT_EN` defined: the `tcnt` counter, abort path and sticky `err_timeout` are built.
- `PCPI_BRIDGE_TIMEOUT_EN` undefined: ISSUE waits indefinitely for `pcpi_ready`. `err_timeout` is tied to 0 and TIMEOUT_CYC is unused.

## Structure
- Shared package `pcpi_bridge_pkg` contains:
  - the state enum: LOAD = 2'b00, ISSUE = 2'b01, UNLOAD = 2'b10;
  - the default SEG_W, INSN_W and RES_W constants;
  - a `clog2`-based index-width helper.
- Sub-module `pcpi_seg_serializer`: the parallel-load, segment-indexed output mux for the result. It has load and advance inputs and an `idx` output.
- Instruction assembly and the FSM stay in the top module.

## Test plan
- Reset mid-ISSUE → `pcpi_valid` = 0, `seg_ready` = 1, `busy` = 0 on the same cycle the reset is asserted.
- Load segments 0x3,0x0,0x0,0x0,0x0,0x0,0x0,0xB back-to-back → `pcpi_insn` = 0xB0000003. `pcpi_valid` rises one cycle after the 8th segment and holds through 5 stall cycles until `pcpi_ready`.
- `pcpi_ready` with `pcpi_wr` = 1 and `pcpi_rd` = 0x12345678, `res_ready` tied high → `res_seg` sequence is 8,7,6,5,4,3,2,1, then `seg_ready` = 1.
- `pcpi_ready` with `pcpi_wr` = 0 → no `res_valid`; `seg_ready` = 1 the next cycle.
- Macro enabled, TIMEOUT_CYC = 8, `pcpi_wait` = 0, no ready → abort after 8 ISSUE cycles and `err_timeout` = 1. Repeat with `pcpi_wait` = 1 for 20 cycles → no abort.
- SEG_W = 8, INSN_W = 32, `res_ready` toggled every other cycle → 4 load segments, and each result segment is held until it is consumed.
